// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha20 block sequencing controller.
// Holds the FSM state encoding, default round/counter sizes and round index width.
// No logic lives here; only declarations shared by the controller and its round counter.
package chacha_pkg;

    localparam int CHACHA_ROUNDS   = 20;
    localparam int CHACHA_CTR_BITS = 32;

    // Wide enough to hold round indices 0..CHACHA_ROUNDS inclusive.
    localparam int ROUND_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    // Width of a counter that must reach lat-1; never below one bit.
    function automatic int lat_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/chacha_round_counter.sv
// Round sequencer: latency counter plus round index for the ChaCha round loop.
// Latency: load_o fires when the latency counter reaches QR_LATENCY-1, decoded from flops only.
// Backpressure: none; advances only while adv_i is high, frozen otherwise.
module chacha_round_counter
    import chacha_pkg::*;
#(
    parameter int ROUNDS     = CHACHA_ROUNDS,
    parameter int QR_LATENCY = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               in_round_i,
    input  logic               adv_i,
    output logic [ROUND_W-1:0] round_o,
    output logic               load_o,
    output logic               last_o,
    output logic               diag_o
);

    localparam int LAT_W = lat_width(QR_LATENCY);

    logic [LAT_W-1:0]   lat_q;
    logic [ROUND_W-1:0] round_q;
    logic               tick;

    // The round result is loadable on the final latency cycle of the round.
    assign tick    = (lat_q == LAT_W'(QR_LATENCY - 1));
    assign load_o  = in_round_i & tick;
    assign last_o  = (round_q == ROUND_W'(ROUNDS - 1));
    assign diag_o  = round_q[0];
    assign round_o = round_q;

    // Latency counter wraps each round; round index steps on the wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_q   <= '0;
            round_q <= '0;
        end else if (clr_i) begin
            lat_q   <= '0;
            round_q <= '0;
        end else if (adv_i) begin
            if (tick) begin
                lat_q   <= '0;
                round_q <= round_q + ROUND_W'(1);
            end else begin
                lat_q   <= lat_q + LAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/chacha_block_ctrl.sv
// ChaCha20 block controller: sequences init load, ROUNDS round loads, final add-back, then output.
// Latency: start at T -> LOAD T+1, round k at T+1+k*QR_LATENCY, FINAL one cycle later, valid next.
// Backpressure: out_valid_o holds until out_ready_i; start accepted only in IDLE.
module chacha_block_ctrl
    import chacha_pkg::*;
#(
    parameter int ROUNDS     = CHACHA_ROUNDS,
    parameter int QR_LATENCY = 1,
    parameter int CTR_BITS   = CHACHA_CTR_BITS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_valid_i,
    output logic                start_ready_o,
    input  logic                cont_i,
    input  logic                abort_i,
    input  logic                ctr_load_i,
    input  logic [CTR_BITS-1:0] ctr_i,
    output logic [CTR_BITS-1:0] ctr_o,
    output logic                init_load_o,
    output logic                round_load_o,
    output logic                diag_o,
    output logic                final_load_o,
    output logic [ROUND_W-1:0]  round_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                ctr_wrap_o,
    output logic                busy_o
);

    state_e              state_q;
    logic [CTR_BITS-1:0] ctr_q;
    logic [CTR_BITS-1:0] ctr_inc_d;
    logic                wrap_q;
    logic                rc_load;
    logic                rc_last;
    logic                rc_clr;
    logic                rc_in_round;
    logic                rc_adv;

    assign rc_clr      = (state_q == ST_LOAD);
    assign rc_in_round = (state_q == ST_ROUND);
    // An abort freezes the round index so it keeps showing where the block stopped.
    assign rc_adv      = rc_in_round & ~abort_i;

    chacha_round_counter #(
        .ROUNDS     (ROUNDS),
        .QR_LATENCY (QR_LATENCY)
    ) u_round_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (rc_clr),
        .in_round_i (rc_in_round),
        .adv_i      (rc_adv),
        .round_o    (round_o),
        .load_o     (rc_load),
        .last_o     (rc_last),
        .diag_o     (diag_o)
    );

    // Counter increments modulo 2^CTR_BITS; the carry-out is detected separately.
    assign ctr_inc_d = ctr_q + CTR_BITS'(1);

    // Main sequencer: state, block counter and sticky wrap flag; abort overrides everything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
            wrap_q  <= 1'b0;
        end else if (abort_i) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctr_load_i) begin
                        ctr_q  <= ctr_i;
                        wrap_q <= 1'b0;
                    end
                    if (start_valid_i) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (rc_load && rc_last) begin
                        state_q <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    state_q <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        ctr_q <= ctr_inc_d;
                        if (&ctr_q) begin
                            wrap_q <= 1'b1;
                        end
                        state_q <= cont_i ? ST_LOAD : ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs are decoded from flops; only start_ready_o mirrors the idle state directly.
    assign start_ready_o = (state_q == ST_IDLE);
    assign busy_o        = (state_q != ST_IDLE);
    assign init_load_o   = (state_q == ST_LOAD);
    assign round_load_o  = rc_load;
    assign final_load_o  = (state_q == ST_FINAL);
    assign out_valid_o   = (state_q == ST_OUT);
    assign ctr_o         = ctr_q;
    assign ctr_wrap_o    = wrap_q;

endmodule

// File: tb/tb_chacha_block_ctrl.sv
// Directed bench for chacha_block_ctrl: default build plus an 8-round, 3-cycle-latency build.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled there too.
// Each scenario task checks its own hand-derived expectations inline.
module tb_chacha_block_ctrl;

    logic        clk;
    logic        rst_n;

    // Default instance signals
    logic        start_valid, cont, abort, ctr_load, out_ready;
    logic [31:0] ctr_in;
    logic        start_ready, init_load, round_load, diag, final_load, out_valid, ctr_wrap, busy;
    logic [31:0] ctr_out;
    logic [4:0]  round_idx;

    // Short instance signals (ROUNDS=8, QR_LATENCY=3)
    logic        s8_start_valid, s8_out_ready;
    logic        s8_start_ready, s8_init_load, s8_round_load, s8_diag, s8_final_load;
    logic        s8_out_valid, s8_ctr_wrap, s8_busy;
    logic [31:0] s8_ctr_out;
    logic [4:0]  s8_round_idx;

    int n_chk;
    int n_fail;

    chacha_block_ctrl u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_valid_i (start_valid),
        .start_ready_o (start_ready),
        .cont_i        (cont),
        .abort_i       (abort),
        .ctr_load_i    (ctr_load),
        .ctr_i         (ctr_in),
        .ctr_o         (ctr_out),
        .init_load_o   (init_load),
        .round_load_o  (round_load),
        .diag_o        (diag),
        .final_load_o  (final_load),
        .round_o       (round_idx),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .ctr_wrap_o    (ctr_wrap),
        .busy_o        (busy)
    );

    chacha_block_ctrl #(
        .ROUNDS     (8),
        .QR_LATENCY (3),
        .CTR_BITS   (32)
    ) u_dut8 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_valid_i (s8_start_valid),
        .start_ready_o (s8_start_ready),
        .cont_i        (1'b0),
        .abort_i       (1'b0),
        .ctr_load_i    (1'b0),
        .ctr_i         (32'h0),
        .ctr_o         (s8_ctr_out),
        .init_load_o   (s8_init_load),
        .round_load_o  (s8_round_load),
        .diag_o        (s8_diag),
        .final_load_o  (s8_final_load),
        .round_o       (s8_round_idx),
        .out_valid_o   (s8_out_valid),
        .out_ready_i   (s8_out_ready),
        .ctr_wrap_o    (s8_ctr_wrap),
        .busy_o        (s8_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_chk++;
        if ({init_load, round_load, final_load, out_valid, busy, ctr_wrap} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {init_load, round_load, final_load, out_valid, busy, ctr_wrap});
        end
        n_chk++;
        if (ctr_out !== 32'h0 || round_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_ctr: ctr=%h round=%0d want 0/0", ctr_out, round_idx);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (start_ready !== 1'b1 || s8_start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b/%b want 1/1", start_ready, s8_start_ready);
        end
    endtask

    task automatic test_basic_block();
        logic [3:0] exp_pv;
        ctr_load = 1'b1; ctr_in = 32'd5;
        tick();
        ctr_load = 1'b0;
        n_chk++;
        if (ctr_out !== 32'd5) begin
            n_fail++;
            $display("FAIL basic_ctr_load: got %h want 5", ctr_out);
        end
        start_valid = 1'b1; out_ready = 1'b1; cont = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            start_valid = 1'b0;
            if (c == 1)                exp_pv = 4'b1000;
            else if (c <= 21)          exp_pv = 4'b0100;
            else if (c == 22)          exp_pv = 4'b0010;
            else if (c == 23)          exp_pv = 4'b0001;
            else                       exp_pv = 4'b0000;
            n_chk++;
            if ({init_load, round_load, final_load, out_valid} !== exp_pv) begin
                n_fail++;
                $display("FAIL basic_pulses T+%0d: got %b want %b", c,
                         {init_load, round_load, final_load, out_valid}, exp_pv);
            end
            if (c >= 2 && c <= 21) begin
                n_chk++;
                if (diag !== 1'(c % 2 == 1)) begin
                    n_fail++;
                    $display("FAIL basic_diag T+%0d: got %b want %b", c, diag, 1'(c % 2 == 1));
                end
            end
        end
        n_chk++;
        if (ctr_out !== 32'd6 || start_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_after: ctr=%h ready=%b want 6/1", ctr_out, start_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        start_valid = 1'b1; out_ready = 1'b0;
        tick();
        start_valid = 1'b0;
        repeat (22) tick();
        for (int i = 0; i < 10; i++) begin
            n_chk++;
            if (out_valid !== 1'b1 || ctr_out !== 32'd6 || start_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: valid=%b ctr=%h ready=%b want 1/6/0",
                         i, out_valid, ctr_out, start_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0 || ctr_out !== 32'd7 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ctr=%h busy=%b want 0/7/0", out_valid, ctr_out, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_ctr [3];
        exp_ctr[0] = 32'hFFFF_FFFE;
        exp_ctr[1] = 32'hFFFF_FFFF;
        exp_ctr[2] = 32'h0000_0000;
        ctr_load = 1'b1; ctr_in = 32'hFFFF_FFFE;
        tick();
        ctr_load = 1'b0;
        start_valid = 1'b1; cont = 1'b1; out_ready = 1'b1;
        tick();
        start_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            n_chk++;
            if (init_load !== 1'b1 || ctr_out !== exp_ctr[b] || ctr_wrap !== 1'(b == 2)) begin
                n_fail++;
                $display("FAIL b2b_load blk%0d: init=%b ctr=%h wrap=%b want 1/%h/%b",
                         b, init_load, ctr_out, ctr_wrap, exp_ctr[b], 1'(b == 2));
            end
            if (b == 2) cont = 1'b0;
            for (int j = 1; j <= 22; j++) begin
                tick();
                n_chk++;
                if (busy !== 1'b1 || out_valid !== 1'(j == 22)) begin
                    n_fail++;
                    $display("FAIL b2b_run blk%0d +%0d: busy=%b valid=%b want 1/%b",
                             b, j, busy, out_valid, 1'(j == 22));
                end
            end
            tick();
        end
        n_chk++;
        if (busy !== 1'b0 || ctr_out !== 32'd1 || ctr_wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end: busy=%b ctr=%h wrap=%b want 0/1/1", busy, ctr_out, ctr_wrap);
        end
        out_ready = 1'b0;
        ctr_load = 1'b1; ctr_in = 32'h0;
        tick();
        ctr_load = 1'b0;
        n_chk++;
        if (ctr_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_clear: got %b want 0", ctr_wrap);
        end
    endtask

    task automatic test_latency3();
        logic [3:0] exp_pv;
        s8_start_valid = 1'b1; s8_out_ready = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            tick();
            s8_start_valid = 1'b0;
            if (c == 1)                                  exp_pv = 4'b1000;
            else if (c >= 4 && c <= 25 && (c - 1) % 3 == 0) exp_pv = 4'b0100;
            else if (c == 26)                            exp_pv = 4'b0010;
            else if (c == 27)                            exp_pv = 4'b0001;
            else                                         exp_pv = 4'b0000;
            n_chk++;
            if ({s8_init_load, s8_round_load, s8_final_load, s8_out_valid} !== exp_pv) begin
                n_fail++;
                $display("FAIL lat3_pulses T+%0d: got %b want %b", c,
                         {s8_init_load, s8_round_load, s8_final_load, s8_out_valid}, exp_pv);
            end
            if (exp_pv == 4'b0100) begin
                n_chk++;
                if (s8_diag !== 1'(((c - 1) / 3 - 1) % 2 == 1)) begin
                    n_fail++;
                    $display("FAIL lat3_diag T+%0d: got %b want %b", c, s8_diag,
                             1'(((c - 1) / 3 - 1) % 2 == 1));
                end
            end
        end
        n_chk++;
        if (s8_ctr_out !== 32'd1 || s8_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lat3_end: ctr=%h busy=%b want 1/0", s8_ctr_out, s8_busy);
        end
        s8_out_ready = 1'b0;
    endtask

    task automatic test_ctr_load_start();
        ctr_load = 1'b1; ctr_in = 32'h10; start_valid = 1'b1; out_ready = 1'b1; cont = 1'b0;
        tick();
        ctr_load = 1'b0; start_valid = 1'b0;
        n_chk++;
        if (init_load !== 1'b1 || ctr_out !== 32'h10) begin
            n_fail++;
            $display("FAIL same_cycle_load: init=%b ctr=%h want 1/10", init_load, ctr_out);
        end
        tick();
        ctr_load = 1'b1; ctr_in = 32'h99;
        tick();
        ctr_load = 1'b0;
        n_chk++;
        if (ctr_out !== 32'h10) begin
            n_fail++;
            $display("FAIL busy_ctr_load_ignored: got %h want 10", ctr_out);
        end
        repeat (21) tick();
        n_chk++;
        if (busy !== 1'b0 || ctr_out !== 32'h11) begin
            n_fail++;
            $display("FAIL load_start_end: busy=%b ctr=%h want 0/11", busy, ctr_out);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        ctr_load = 1'b1; ctr_in = 32'h40;
        tick();
        ctr_load = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        repeat (7) tick();
        n_chk++;
        if (round_load !== 1'b1 || round_idx !== 5'd6) begin
            n_fail++;
            $display("FAIL abort_pre: rload=%b round=%0d want 1/6", round_load, round_idx);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if ({init_load, round_load, final_load, out_valid, busy} !== 5'b0 ||
                start_ready !== 1'b1 || ctr_out !== 32'h40 || ctr_wrap !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_round +%0d: pv=%b ready=%b ctr=%h wrap=%b want 00000/1/40/0", i,
                         {init_load, round_load, final_load, out_valid, busy}, start_ready, ctr_out, ctr_wrap);
            end
            tick();
        end
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        repeat (22) tick();
        n_chk++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_out_reach: valid=%b want 1", out_valid);
        end
        abort = 1'b1; out_ready = 1'b1; cont = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0; cont = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || init_load !== 1'b0 || ctr_out !== 32'h40) begin
            n_fail++;
            $display("FAIL abort_out: busy=%b valid=%b init=%b ctr=%h want 0/0/0/40",
                     busy, out_valid, init_load, ctr_out);
        end
    endtask

    task automatic test_reset_mid();
        ctr_load = 1'b1; ctr_in = 32'h77;
        tick();
        ctr_load = 1'b0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({init_load, round_load, final_load, out_valid, busy, ctr_wrap} !== 6'b0 ||
            ctr_out !== 32'h0 || round_idx !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_mid: pv=%b ctr=%h round=%0d want 000000/0/0",
                     {init_load, round_load, final_load, out_valid, busy, ctr_wrap}, ctr_out, round_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: ready=%b busy=%b want 1/0", start_ready, busy);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        start_valid = 1'b0; cont = 1'b0; abort = 1'b0; ctr_load = 1'b0;
        out_ready = 1'b0; ctr_in = 32'h0;
        s8_start_valid = 1'b0; s8_out_ready = 1'b0;
        test_reset();
        test_basic_block();
        test_backpressure();
        test_back_to_back();
        test_latency3();
        test_ctr_load_start();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
